// File: rtl/fp_pkg.sv
// Shared floating-point definitions: rounding modes, operand classes, flag bit
// positions and helpers that derive constant encodings from the field widths.
package fp_pkg;

  localparam logic RM_RNE = 1'b0;
  localparam logic RM_RTZ = 1'b1;

  typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} fp_class_e;

  // Result tag decided at unpack time; SP_NONE means the arithmetic path is used.
  typedef enum logic [1:0] {SP_NONE, SP_ZERO, SP_INF, SP_NAN} fp_special_e;

  localparam int FLAG_INEXACT   = 0;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_INVALID   = 3;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

  function automatic logic [63:0] fp_max_finite(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd2) << man_w) | ((64'd1 << man_w) - 64'd1);
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Combinational normalise / round / range-check / pack stage for a raw mantissa
// product with a biased exponent; shared by multiplier and future adder pipes.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W,
  localparam int PW    = 2 * MAN_W + 2,
  localparam int EW    = EXP_W + 2
) (
  input  logic                 i_sign,
  input  logic signed [EW-1:0] i_exp,
  input  logic        [PW-1:0] i_prod,
  input  logic                 i_rm,
  output logic        [W-1:0]  o_result,
  output logic        [3:0]    o_flags
);

  localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0]         MAX_FIN = W'(fp_max_finite(EXP_W, MAN_W));

  logic                 w_shift;
  logic        [PW-2:0] w_norm;
  logic        [MAN_W-1:0] w_frac;
  logic                 w_guard;
  logic                 w_sticky;
  logic                 w_inc;
  logic        [MAN_W:0] w_frac_rnd;
  logic signed [EW-1:0] w_exp_rnd;
  logic                 w_ovf;
  logic                 w_unf;

  // After normalising, the hidden 1 sits just above w_norm; it is implied, not stored.
  assign w_shift    = i_prod[PW-1];
  assign w_norm     = w_shift ? i_prod[PW-2:0] : {i_prod[PW-3:0], 1'b0};
  assign w_frac     = w_norm[PW-2 -: MAN_W];
  assign w_guard    = w_norm[MAN_W];
  assign w_sticky   = |w_norm[MAN_W-1:0];
  assign w_inc      = (i_rm == RM_RNE) && w_guard && (w_sticky || w_frac[0]);
  assign w_frac_rnd = {1'b0, w_frac} + {{MAN_W{1'b0}}, w_inc};
  assign w_exp_rnd  = i_exp + {{(EW-1){1'b0}}, w_shift} + {{(EW-1){1'b0}}, w_frac_rnd[MAN_W]};
  assign w_ovf      = (w_exp_rnd >= EXP_MAX);
  assign w_unf      = w_exp_rnd[EW-1] || (w_exp_rnd == '0);

  always_comb begin
    // NOTE: every output gets a default before any branch so no path can infer a latch.
    o_flags               = '0;
    o_flags[FLAG_INEXACT] = w_guard | w_sticky;
    o_result              = {i_sign, w_exp_rnd[EXP_W-1:0], w_frac_rnd[MAN_W-1:0]};
    if (w_ovf) begin
      o_flags[FLAG_OVERFLOW] = 1'b1;
      o_flags[FLAG_INEXACT]  = 1'b1;
      o_result = (i_rm == RM_RTZ) ? {i_sign, MAX_FIN[W-2:0]}
                                  : {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_unf) begin
      o_flags[FLAG_UNDERFLOW] = 1'b1;
      o_flags[FLAG_INEXACT]   = 1'b1;
      o_result = {i_sign, {(W-1){1'b0}}};
    end
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage floating-point multiplier: S1 unpack/classify, S2 mantissa product,
// S3 round/pack into the output register; a single advance enable stalls the pipe.
module fp_mult_pipe
  import fp_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         round_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);

  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;
  localparam logic signed [EW-1:0] BIAS = EW'(fp_bias(EXP_W));
  localparam logic [W-1:0]         QNAN = W'(fp_qnan(EXP_W, MAN_W));

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (e == '0) return CLS_ZERO;
    if (e == '1) return (f == '0) ? CLS_INF : CLS_NAN;
    return CLS_NORM;
  endfunction

  logic                 w_advance;
  fp_class_e            w_cls_a;
  fp_class_e            w_cls_b;
  logic                 w_zero_inf;
  logic                 w_snan;
  fp_special_e          w_special;
  logic                 w_invalid;
  logic signed [EW-1:0] w_exp_sum;
  logic [W-1:0]         w_rp_result;
  logic [3:0]           w_rp_flags;
  logic [W-1:0]         w_s3_result;
  logic [3:0]           w_s3_flags;

  logic                 r1_valid;
  logic                 r1_sign;
  logic signed [EW-1:0] r1_exp;
  logic [MAN_W:0]       r1_man_a;
  logic [MAN_W:0]       r1_man_b;
  fp_special_e          r1_special;
  logic                 r1_invalid;
  logic                 r1_rm;

  logic                 r2_valid;
  logic                 r2_sign;
  logic signed [EW-1:0] r2_exp;
  logic [PW-1:0]        r2_prod;
  fp_special_e          r2_special;
  logic                 r2_invalid;
  logic                 r2_rm;

  logic                 r_out_valid;
  logic [W-1:0]         r_result;
  logic [3:0]           r_flags;

  assign w_advance = !r_out_valid || out_ready;
  assign in_ready  = w_advance;

  assign w_cls_a    = classify(a[W-2 -: EXP_W], a[MAN_W-1:0]);
  assign w_cls_b    = classify(b[W-2 -: EXP_W], b[MAN_W-1:0]);
  assign w_zero_inf = ((w_cls_a == CLS_ZERO) && (w_cls_b == CLS_INF)) ||
                      ((w_cls_a == CLS_INF)  && (w_cls_b == CLS_ZERO));
  assign w_snan     = ((w_cls_a == CLS_NAN) && !a[MAN_W-1]) ||
                      ((w_cls_b == CLS_NAN) && !b[MAN_W-1]);
  assign w_exp_sum  = {2'b00, a[W-2 -: EXP_W]} + {2'b00, b[W-2 -: EXP_W]} - BIAS;

  // Priority: NaN (incl. 0*inf) beats inf, inf beats zero, zero beats arithmetic.
  always_comb begin
    w_special = SP_NONE;
    w_invalid = 1'b0;
    if ((w_cls_a == CLS_NAN) || (w_cls_b == CLS_NAN) || w_zero_inf) begin
      w_special = SP_NAN;
      w_invalid = w_zero_inf || w_snan;
    end else if ((w_cls_a == CLS_INF) || (w_cls_b == CLS_INF)) begin
      w_special = SP_INF;
    end else if ((w_cls_a == CLS_ZERO) || (w_cls_b == CLS_ZERO)) begin
      w_special = SP_ZERO;
    end
  end

  fp_round_pack #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round_pack (
    .i_sign   (r2_sign),
    .i_exp    (r2_exp),
    .i_prod   (r2_prod),
    .i_rm     (r2_rm),
    .o_result (w_rp_result),
    .o_flags  (w_rp_flags)
  );

  always_comb begin
    w_s3_result = w_rp_result;
    w_s3_flags  = w_rp_flags;
    case (r2_special)
      SP_NAN: begin
        w_s3_result               = QNAN;
        w_s3_flags                = '0;
        w_s3_flags[FLAG_INVALID]  = r2_invalid;
      end
      SP_INF: begin
        w_s3_result = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        w_s3_flags  = '0;
      end
      SP_ZERO: begin
        w_s3_result = {r2_sign, {(W-1){1'b0}}};
        w_s3_flags  = '0;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking <= so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_valid    <= 1'b0;
      r2_valid    <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
    end else if (w_advance) begin
      r1_valid    <= in_valid;
      r2_valid    <= r1_valid;
      r_out_valid <= r2_valid;
      if (r2_valid) begin
        r_result <= w_s3_result;
        r_flags  <= w_s3_flags;
      end
    end
  end

  // NOTE: datapath stage registers have no reset; they are only consumed when the
  // matching valid bit is set, and that bit is cleared by rst.
  always_ff @(posedge clk) begin
    if (w_advance) begin
      r1_sign    <= a[W-1] ^ b[W-1];
      r1_exp     <= w_exp_sum;
      r1_man_a   <= {1'b1, a[MAN_W-1:0]};
      r1_man_b   <= {1'b1, b[MAN_W-1:0]};
      r1_special <= w_special;
      r1_invalid <= w_invalid;
      r1_rm      <= round_mode;

      r2_sign    <= r1_sign;
      r2_exp     <= r1_exp;
      r2_prod    <= PW'(r1_man_a) * PW'(r1_man_b);
      r2_special <= r1_special;
      r2_invalid <= r1_invalid;
      r2_rm      <= r1_rm;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flags     = r_flags;

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Scoreboard bench for fp_mult_pipe: directed corner cases, stalls, random traffic
// against an exact-arithmetic reference, and a mid-stream reset.
module tb_fp_mult_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        round_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int next_id  = 0;
  bit rand_done;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    int          acc;
    bit          lat;
    int          id;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  bit          hold_v = 1'b0;
  logic [31:0] hold_res;
  logic [3:0]  hold_flg;

  fp_mult_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .round_mode (round_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .flags      (flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: exact integer product, then round by remainder against half an ulp.
  function automatic void model(input logic [31:0] x, input logic [31:0] y, input bit rm,
                                output logic [31:0] r, output logic [3:0] f);
    bit s, zx, zy, ix, iy, nx, ny;
    int ex, ey, msb, sh, e;
    longint unsigned fx, fy, p, q, rem, half;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    fx = 64'(x[22:0]);
    fy = 64'(y[22:0]);
    zx = (ex == 0);
    zy = (ey == 0);
    ix = (ex == 255) && (fx == 0);
    iy = (ey == 255) && (fy == 0);
    nx = (ex == 255) && (fx != 0);
    ny = (ey == 255) && (fy != 0);
    r  = '0;
    f  = '0;
    if (nx || ny || (zx && iy) || (ix && zy)) begin
      r    = 32'h7FC00000;
      f[3] = (zx && iy) || (ix && zy) || (nx && !x[22]) || (ny && !y[22]);
    end else if (ix || iy) begin
      r = {s, 8'hFF, 23'h0};
    end else if (zx || zy) begin
      r = {s, 31'h0};
    end else begin
      p   = (fx + 64'h800000) * (fy + 64'h800000);
      msb = 0;
      for (int i = 0; i < 64; i++) if (p[i]) msb = i;
      sh   = msb - 23;
      e    = ex + ey - 127 + (msb - 46);
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
      if (!rm && ((rem > half) || ((rem == half) && q[0]))) q = q + 1;
      if (q == 64'h1000000) begin
        q = q >> 1;
        e = e + 1;
      end
      if (e >= 255) begin
        f = 4'b0101;
        r = rm ? {s, 31'h7F7FFFFF} : {s, 8'hFF, 23'h0};
      end else if (e <= 0) begin
        f = 4'b0011;
        r = {s, 31'h0};
      end else begin
        r = {s, 8'(e), q[22:0]};
        f = {3'b000, rem != 0};
      end
    end
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 9))
      0: v[30:23] = 8'h00;
      1: v[30:23] = 8'hFF;
      2: begin v[30:23] = 8'hFF; v[22:0] = '0; end
      3, 4: v[30:23] = 8'($urandom_range(1, 254));
      5: begin v[30:23] = 8'($urandom_range(100, 154)); v[15:0] = '0; end
      default: v[30:23] = 8'($urandom_range(100, 154));
    endcase
    return v;
  endfunction

  // Called just after a rising edge; returns just after the edge that took the operands.
  task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input bit rm,
                      input logic [31:0] er, input logic [3:0] ef, input bit lat);
    int   waited;
    exp_t e;
    waited     = 0;
    in_valid   = 1'b1;
    a          = ta;
    b          = tb_v;
    round_mode = rm;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready=0 required=1 (t=%0t)", $time);
    end else begin
      e.res = er;
      e.flg = ef;
      e.acc = cyc;
      e.lat = lat;
      e.id  = next_id;
      next_id++;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input bit lat);
    logic [31:0] ra, rb, er;
    logic [3:0]  ef;
    bit          rm;
    ra = rand_op();
    rb = rand_op();
    rm = 1'($urandom_range(0, 1));
    model(ra, rb, rm, er, ef);
    send(ra, rb, rm, er, ef, lat);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_result", result, hold_res);
        check("hold_flags", 32'(flags), 32'(hold_flg));
      end
      check("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: actual=%h required=none (t=%0t)", result, $time);
        end else begin
          mon_e = sb.pop_front();
          check($sformatf("result[%0d]", mon_e.id), result, mon_e.res);
          check($sformatf("flags[%0d]", mon_e.id), 32'(flags), 32'(mon_e.flg));
          if (mon_e.lat) check($sformatf("latency[%0d]", mon_e.id), 32'(cyc - mon_e.acc), 32'd3);
        end
      end
      hold_v   = out_valid && !out_ready;
      hold_res = result;
      hold_flg = flags;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    a          = '0;
    b          = '0;
    round_mode = 1'b0;
    out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_flags", 32'(flags), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    send(32'h3F800000, 32'h40000000, 1'b0, 32'h40000000, 4'b0000, 1'b1);
    send(32'hBF800000, 32'h3FC00000, 1'b0, 32'hBFC00000, 4'b0000, 1'b1);
    send(32'hBF800000, 32'hBF800000, 1'b0, 32'h3F800000, 4'b0000, 1'b1);
    send(32'h3E4CCCCD, 32'h3E4CCCCD, 1'b0, 32'h3D23D70B, 4'b0001, 1'b1);
    send(32'h3E4CCCCD, 32'h3E4CCCCD, 1'b1, 32'h3D23D70A, 4'b0001, 1'b1);
    send(32'h7F000000, 32'h7F000000, 1'b0, 32'h7F800000, 4'b0101, 1'b1);
    send(32'h7F000000, 32'h7F000000, 1'b1, 32'h7F7FFFFF, 4'b0101, 1'b1);
    send(32'h00800000, 32'h00800000, 1'b0, 32'h00000000, 4'b0011, 1'b1);
    send(32'h00000000, 32'h7F800000, 1'b0, 32'h7FC00000, 4'b1000, 1'b1);
    send(32'h7F800000, 32'hC0000000, 1'b0, 32'hFF800000, 4'b0000, 1'b1);
    send(32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, 1'b1);
    send(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000, 1'b1);
    send(32'h3F800000, 32'h7F7FFFFF, 1'b0, 32'h7F7FFFFF, 4'b0000, 1'b1);
    send(32'h00400000, 32'h40000000, 1'b0, 32'h00000000, 4'b0000, 1'b1);
    send(32'h80000000, 32'h3F800000, 1'b0, 32'h80000000, 4'b0000, 1'b1);
    drain();

    fork
      begin
        for (int i = 0; i < 8; i++) send_rand(1'b0);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          check("stall_in_ready", 32'(in_ready), 32'd0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) send_rand(1'b0);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    for (int i = 0; i < 4; i++) send_rand(1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_flags", 32'(flags), 32'd0);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("post_reset_idle", 32'(out_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
